// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 serial joystick link (joy_db15 receiver and
// joy_db15_tx adapter-side transmitter).
//
// Contents:
//   BITS_PER_PLAYER_DEF / FRAME_BITS_DEF : default button-word and frame widths
//   state_t                               : transmitter frame state
//   BTN_*                                 : bit positions inside a player's button word
package joy_db15_pkg;

   localparam int BITS_PER_PLAYER_DEF = 12;
   localparam int FRAME_BITS_DEF      = 2 * BITS_PER_PLAYER_DEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Button word layout, bit 0 first on the wire.
   localparam int BTN_R     = 0;
   localparam int BTN_L     = 1;
   localparam int BTN_DN    = 2;
   localparam int BTN_UP    = 3;
   localparam int BTN_A     = 4;
   localparam int BTN_B     = 5;
   localparam int BTN_C     = 6;
   localparam int BTN_D     = 7;
   localparam int BTN_START = 8;
   localparam int BTN_MODE  = 9;
   localparam int BTN_E     = 10;
   localparam int BTN_F     = 11;

endpackage

// File: rtl/joy_sync_edge.sv
// Synchronizer and edge detector for one asynchronous strobe input.
//
// Ports:
//   clk     in  core clock
//   reset   in  asynchronous active-high reset
//   din_i   in  asynchronous input pin
//   level_o out synchronized level (last synchronizer stage)
//   rise_o  out one-cycle pulse on a synchronized 0->1 transition
//   fall_o  out one-cycle pulse on a synchronized 1->0 transition
//
// All flops reset to 1 so an idle (high) strobe produces no edge after reset.
module joy_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
         edge_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  =  sync_q[SYNC_STAGES-1] & ~edge_q;
   assign fall_o  = ~sync_q[SYNC_STAGES-1] &  edge_q;

endmodule

// File: rtl/joy_db15_tx.sv
// Adapter-side transmitter of the DB15 serial joystick link. Answers the
// receiver's JOY_LOAD / JOY_CLK strobes by shifting two players' button words
// out on JOY_DATA, bit 0 of player 1 first, active-low on the wire.
//
// Ports:
//   clk        in  core clock
//   reset      in  asynchronous active-high reset
//   joystick1  in  player-1 buttons, active-high
//   joystick2  in  player-2 buttons, active-high
//   joy_load_n in  JOY_LOAD strobe (async, active-low parallel load)
//   joy_clk    in  JOY_CLK strobe (async, rising edge advances the shift)
//   joy_data   out JOY_DATA, idles high
//   snap_stb   out one-cycle pulse when a snapshot is taken
//   busy       out high while a frame is loaded or shifting
//
// Build option: define JOY_DB15_TX_WATCHDOG_EN to abort a frame after
// TIMEOUT_CYCLES clocks without any strobe edge (receiver unplugged).
module joy_db15_tx
   import joy_db15_pkg::*;
#(
   parameter int BITS_PER_PLAYER = BITS_PER_PLAYER_DEF,
   parameter int SYNC_STAGES     = 2
`ifdef JOY_DB15_TX_WATCHDOG_EN
   ,
   parameter int TIMEOUT_CYCLES  = 4800
`endif
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [BITS_PER_PLAYER-1:0] joystick1,
   input  logic [BITS_PER_PLAYER-1:0] joystick2,
   input  logic                       joy_load_n,
   input  logic                       joy_clk,
   output logic                       joy_data,
   output logic                       snap_stb,
   output logic                       busy
);

   localparam int FRAME_BITS = 2 * BITS_PER_PLAYER;
   localparam int CW         = $clog2(FRAME_BITS + 1);

   logic load_lvl, load_rise, load_fall;
   logic clk_lvl, clk_rise, clk_fall;

   joy_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
      .clk     (clk),
      .reset   (reset),
      .din_i   (joy_load_n),
      .level_o (load_lvl),
      .rise_o  (load_rise),
      .fall_o  (load_fall)
   );

   joy_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .clk     (clk),
      .reset   (reset),
      .din_i   (joy_clk),
      .level_o (clk_lvl),
      .rise_o  (clk_rise),
      .fall_o  (clk_fall)
   );

   // Level and falling edge of JOY_CLK carry no meaning for the shifter.
   logic unused_clk_bits;
   assign unused_clk_bits = ^{clk_lvl, clk_fall};

   state_t                  state_q, state_d;
   logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
   logic [CW-1:0]           cnt_q,   cnt_d;
   logic                    snap_q,  snap_d;

`ifdef JOY_DB15_TX_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wd_q, wd_d;
   logic          any_edge;

   assign any_edge = load_rise | load_fall | clk_rise | clk_fall;

   always_comb begin
      wd_d = wd_q;
      if ((state_q == IDLE) || any_edge)
         wd_d = '0;
      else if (wd_q != WW'(TIMEOUT_CYCLES))
         wd_d = wd_q + WW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) wd_q <= '0;
      else       wd_q <= wd_d;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= '1;
         cnt_q   <= '0;
         snap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      snap_d  = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (!load_lvl) begin
               state_d = LOAD;
               shreg_d = {~joystick2, ~joystick1};
               cnt_d   = '0;
               snap_d  = 1'b1;
            end
         end

         // Transparent while load is held low; clock edges are ignored here.
         LOAD: begin
            if (load_rise) begin
               state_d = SHIFT;
            end else begin
               shreg_d = {~joystick2, ~joystick1};
               cnt_d   = '0;
            end
         end

         // A load edge outranks a simultaneous clock edge.
         SHIFT: begin
            if (load_fall) begin
               state_d = LOAD;
               shreg_d = {~joystick2, ~joystick1};
               cnt_d   = '0;
               snap_d  = 1'b1;
            end else if (clk_rise) begin
               shreg_d = {1'b1, shreg_q[FRAME_BITS-1:1]};
               if (cnt_q == CW'(FRAME_BITS - 1)) begin
                  state_d = DONE;
                  cnt_d   = CW'(FRAME_BITS);
               end else begin
                  cnt_d   = cnt_q + CW'(1);
               end
            end
         end

         default: state_d = IDLE;
      endcase

`ifdef JOY_DB15_TX_WATCHDOG_EN
      if ((state_q != IDLE) && (wd_q == WW'(TIMEOUT_CYCLES))) begin
         state_d = IDLE;
         shreg_d = '1;
         cnt_d   = '0;
         snap_d  = 1'b0;
      end
`endif
   end

   assign busy     = (state_q == LOAD) || (state_q == SHIFT);
   assign joy_data = busy ? shreg_q[0] : 1'b1;
   assign snap_stb = snap_q;

endmodule
